// File: rtl/rotatix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rotatix_pkg                                                                |
// | Shared quadrature types and the Gray-code step decoder.                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package rotatix_pkg;

  typedef logic [1:0] quad_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  localparam int MAX_DEB_CYC = 255;

  function automatic logic [1:0] gray_to_bin(input quad_t g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // The cycle 00,01,11,10 maps to binary 0..3, so the modulo-4 difference
  // gives the step: 1 forward, 3 backward, 2 means both phases moved.
  function automatic step_e quad_decode(input quad_t prev, input quad_t cur);
    logic [1:0] delta;
    step_e      res;
    delta = gray_to_bin(cur) - gray_to_bin(prev);
    case (delta)
      2'd0:    res = STEP_NONE;
      2'd1:    res = STEP_UP;
      2'd3:    res = STEP_DN;
      default: res = STEP_ERR;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rotatix_quad_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rotatix_quad_counter_if                                                    |
// | Encoder pins, control and position outputs of the quadrature counter.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface rotatix_quad_counter_if #(
  parameter int WIDTH = 8
) ();
  logic             enc_a;
  logic             enc_b;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] pos;
  logic             dir;
  logic             step;
  logic             err;

  modport master (
    output enc_a, enc_b, clr, load, load_val,
    input  pos, dir, step, err
  );

  modport slave (
    input  enc_a, enc_b, clr, load, load_val,
    output pos, dir, step, err
  );
endinterface
`default_nettype wire

// File: rtl/rotatix_sync_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rotatix_sync_filter                                                        |
// | 2-flop synchroniser with optional debounce (ROTATIX_DEBOUNCE_EN).          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rotatix_sync_filter
  import rotatix_pkg::*;
#(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic filt
);

  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], pin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

`ifdef ROTATIX_DEBOUNCE_EN
  localparam int                 c_cnt_w    = $clog2(MAX_DEB_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYC - 1);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               filt_q, filt_d;

  // The count restarts whenever the input agrees with the output again,
  // so only an uninterrupted run of DEB_CYC differing samples flips it.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == c_cnt_last) filt_d = sync_q[1];
      else                     cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_q[1];
`endif

endmodule
`default_nettype wire

// File: rtl/rotatix_quad_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rotatix_quad_counter                                                       |
// | Quadrature decoder and signed position counter; ROTATIX_DEBOUNCE_EN adds   |
// | a DEB_CYC debounce filter on each phase.                                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rotatix_quad_counter
  import rotatix_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0,
  parameter int DEB_CYC  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rotatix_quad_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] c_pos_max = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_pos_min = {1'b1, {(WIDTH-1){1'b0}}};

  logic             w_a, w_b;
  quad_t            w_cur;
  step_e            w_dec;
  logic [WIDTH-1:0] w_pos_inc, w_pos_dec;

  quad_t            prev_q, prev_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;

  rotatix_sync_filter #(.DEB_CYC(DEB_CYC)) u_filt_a (
    .clk  (clk),
    .rst_n(rst_n),
    .pin  (bus.enc_a),
    .filt (w_a)
  );

  rotatix_sync_filter #(.DEB_CYC(DEB_CYC)) u_filt_b (
    .clk  (clk),
    .rst_n(rst_n),
    .pin  (bus.enc_b),
    .filt (w_b)
  );

  assign w_cur = {w_a, w_b};
  assign w_dec = quad_decode(prev_q, w_cur);

  if (SATURATE != 0) begin : g_sat
    assign w_pos_inc = (pos_q == c_pos_max) ? pos_q : pos_q + 1'b1;
    assign w_pos_dec = (pos_q == c_pos_min) ? pos_q : pos_q - 1'b1;
  end else begin : g_wrap
    assign w_pos_inc = pos_q + 1'b1;
    assign w_pos_dec = pos_q - 1'b1;
  end

  // prev always follows the pins, even on an illegal jump or a dropped step.
  always_comb begin
    prev_d = w_cur;
    pos_d  = pos_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    err_d  = err_q;
    if (w_dec == STEP_ERR) err_d = 1'b1;
    if (bus.clr) begin
      pos_d = '0;
      err_d = 1'b0;
    end else if (bus.load) begin
      pos_d = bus.load_val;
    end else if (w_dec == STEP_UP) begin
      pos_d  = w_pos_inc;
      dir_d  = 1'b1;
      step_d = 1'b1;
    end else if (w_dec == STEP_DN) begin
      pos_d  = w_pos_dec;
      dir_d  = 1'b0;
      step_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 2'b00;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      err_q  <= err_d;
    end
  end

  assign bus.pos  = pos_q;
  assign bus.dir  = dir_q;
  assign bus.step = step_q;
  assign bus.err  = err_q;

endmodule
`default_nettype wire
